hilo_commit_unit: RTL and testbench

//  Downstream companion of the multiply/divide wrapper. Owns the architectural HI/LO registers.

---
 rtl/hilo_commit_unit.sv | 138 +++++++++++++
 tb/tb_hilo_commit_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_commit_unit.sv
// ----------------------------------------------------------------------------
// hilo_commit_unit
//
// Owns the architectural HI/LO registers that sit downstream of the mul/div
// wrapper. It tracks one in-flight mul/div op, commits its hi/lo result when
// the wrapper drops md_wait, and feeds the committed HI/LO back to the wrapper
// for accumulate ops. It also serves MFHI/MFLO/MTHI/MTLO in program order and
// stalls the execute stage on HI/LO hazards while an op is in flight.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous reset, active low (asserted when 0)
//   flush      : pipeline flush; aborts the in-flight op without commit
//   md_start   : execute issues a mul/div op this cycle
//   md_wait    : wrapper result not ready yet
//   md_hi/lo   : wrapper result
//   mt_hi_we   : MTHI request (data on mt_data)
//   mt_lo_we   : MTLO request (data on mt_data)
//   mt_data    : MTHI/MTLO data
//   mf_req     : MFHI/MFLO request
//   mf_sel_hi  : 1 = MFHI, 0 = MFLO
//   mf_data    : MFHI/MFLO result (combinational)
//   hi_in/lo_in: committed HI/LO to the wrapper
//   md_clear   : clear pulse to the wrapper (reset or flush of an op)
//   stall      : hold the execute stage (combinational)
//   busy       : an op is in flight
// ----------------------------------------------------------------------------
module hilo_commit_unit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             md_start,
    input  logic             md_wait,
    input  logic [WIDTH-1:0] md_hi,
    input  logic [WIDTH-1:0] md_lo,
    input  logic             mt_hi_we,
    input  logic             mt_lo_we,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             mf_req,
    input  logic             mf_sel_hi,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi_in,
    output logic [WIDTH-1:0] lo_in,
    output logic             md_clear,
    output logic             stall,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic in_busy;
    logic commit_cycle;
    logic do_commit;
    logic hazard_req;
    logic mt_ok;

    assign in_busy      = (state == BUSY);
    // The first BUSY cycle with md_wait low is the commit cycle; a flush in
    // that same cycle wins and the result is dropped.
    assign commit_cycle = in_busy && !md_wait;
    assign do_commit    = commit_cycle && !flush;

    // Any request that touches HI/LO, or a second op, must wait until the
    // in-flight result lands.
    assign hazard_req   = md_start || mf_req || mt_hi_we || mt_lo_we;
    assign stall        = in_busy && !commit_cycle && hazard_req;

    assign mt_ok        = !stall && !flush;

    assign md_clear     = !reset || (in_busy && flush);
    assign busy         = in_busy;

    // Accumulate ops must see the committed value, so no bypass here.
    assign hi_in        = hi_reg;
    assign lo_in        = lo_reg;

    // During the commit cycle the result is forwarded; a same-cycle MT is
    // deliberately not forwarded since it is ordered after the MF.
    always_comb begin
        mf_data = '0;
        if (mf_sel_hi) begin
            mf_data = do_commit ? md_hi : hi_reg;
        end else begin
            mf_data = do_commit ? md_lo : lo_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            hi_reg <= RESET_VAL;
            lo_reg <= RESET_VAL;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start && !flush) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (!md_wait) begin
                        // A start in the commit cycle chains straight into
                        // the next op without leaving BUSY.
                        state <= md_start ? BUSY : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // An MT landing in the commit cycle overrides only its own
            // register; the other one still takes the op result.
            if (mt_hi_we && mt_ok) begin
                hi_reg <= mt_data;
            end else if (do_commit) begin
                hi_reg <= md_hi;
            end

            if (mt_lo_we && mt_ok) begin
                lo_reg <= mt_data;
            end else if (do_commit) begin
                lo_reg <= md_lo;
            end
        end
    end

endmodule

// File: tb/tb_hilo_commit_unit.sv
// ----------------------------------------------------------------------------
// tb_hilo_commit_unit
//
// Directed-vector bench for hilo_commit_unit. Inputs are driven just after a
// rising edge; combinational outputs are checked before the next edge and
// registered outputs are checked one step after the edge that updates them.
// ----------------------------------------------------------------------------
module tb_hilo_commit_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             md_start;
    logic             md_wait;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             mt_hi_we;
    logic             mt_lo_we;
    logic [WIDTH-1:0] mt_data;
    logic             mf_req;
    logic             mf_sel_hi;
    logic [WIDTH-1:0] mf_data;
    logic [WIDTH-1:0] hi_in;
    logic [WIDTH-1:0] lo_in;
    logic             md_clear;
    logic             stall;
    logic             busy;

    int numCompared;
    int numMismatched;

    hilo_commit_unit #(
        .WIDTH    (WIDTH),
        .RESET_VAL('0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .md_start (md_start),
        .md_wait  (md_wait),
        .md_hi    (md_hi),
        .md_lo    (md_lo),
        .mt_hi_we (mt_hi_we),
        .mt_lo_we (mt_lo_we),
        .mt_data  (mt_data),
        .mf_req   (mf_req),
        .mf_sel_hi(mf_sel_hi),
        .mf_data  (mf_data),
        .hi_in    (hi_in),
        .lo_in    (lo_in),
        .md_clear (md_clear),
        .stall    (stall),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                               input logic [WIDTH-1:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one cycle's worth of inputs and lets combinational logic settle.
    task automatic applyStimulus(input logic start, input logic wt, input logic fl,
                                 input logic mf, input logic sel_hi,
                                 input logic mthi, input logic mtlo,
                                 input logic [WIDTH-1:0] mtd,
                                 input logic [WIDTH-1:0] mdh,
                                 input logic [WIDTH-1:0] mdl);
        md_start  = start;
        md_wait   = wt;
        flush     = fl;
        mf_req    = mf;
        mf_sel_hi = sel_hi;
        mt_hi_we  = mthi;
        mt_lo_we  = mtlo;
        mt_data   = mtd;
        md_hi     = mdh;
        md_lo     = mdl;
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    endtask

    // Advances to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        reset         = 1'b0;
        idleInputs();

        // Reset state
        #12;
        checkOutput("rst_busy",     {31'd0, busy},     32'd0);
        checkOutput("rst_stall",    {31'd0, stall},    32'd0);
        checkOutput("rst_md_clear", {31'd0, md_clear}, 32'd1);
        checkOutput("rst_hi",       hi_in,             32'd0);
        checkOutput("rst_lo",       lo_in,             32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rel_md_clear", {31'd0, md_clear}, 32'd0);
        step();

        // Preload HI=5, LO=6 via MTHI/MTLO
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h5, '0, '0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h6, '0, '0);
        step();
        idleInputs();
        checkOutput("mt_hi", hi_in, 32'h5);
        checkOutput("mt_lo", lo_in, 32'h6);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, '0, '0, '0);
        checkOutput("mfhi_idle", mf_data, 32'h5);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, '0, '0, '0);
        checkOutput("mflo_idle", mf_data, 32'h6);

        // md_start with flush in IDLE is ignored
        applyStimulus(1, 1, 1, 0, 0, 0, 0, '0, '0, '0);
        step();
        idleInputs();
        checkOutput("start_flush_idle_busy", {31'd0, busy}, 32'd0);

        // Flush in the 2nd BUSY cycle: no commit, md_clear pulse
        applyStimulus(1, 1, 0, 0, 0, 0, 0, '0, '0, '0);
        step();
        checkOutput("fl_busy1", {31'd0, busy}, 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, '0, 32'h111, 32'h222);
        checkOutput("fl_nostall", {31'd0, stall}, 32'd0);
        step();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, '0, 32'h111, 32'h222);
        checkOutput("fl_md_clear", {31'd0, md_clear}, 32'd1);
        step();
        idleInputs();
        checkOutput("fl_idle", {31'd0, busy}, 32'd0);
        checkOutput("fl_hi",   hi_in, 32'h5);
        checkOutput("fl_lo",   lo_in, 32'h6);
        checkOutput("fl_clear_off", {31'd0, md_clear}, 32'd0);

        // MULTU 0xFFFFFFFF * 2 with MFHI one cycle after start
        applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 1, 1, 0, 0, '0, 32'hDEADBEEF, 32'hDEADBEEF);
            checkOutput($sformatf("mul_stall_%0d", i), {31'd0, stall}, 32'd1);
            checkOutput($sformatf("mul_mf_old_%0d", i), mf_data, 32'h5);
            step();
        end
        applyStimulus(0, 0, 0, 1, 1, 0, 0, '0, 32'h1, 32'hFFFFFFFE);
        checkOutput("mul_commit_stall", {31'd0, stall}, 32'd0);
        checkOutput("mul_bypass",       mf_data, 32'h1);
        step();
        idleInputs();
        checkOutput("mul_hi",   hi_in, 32'h1);
        checkOutput("mul_lo",   lo_in, 32'hFFFFFFFE);
        checkOutput("mul_busy", {31'd0, busy}, 32'd0);

        // MTHI stalled during BUSY, then MTLO in the commit cycle
        applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        step();
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h77, '0, '0);
        checkOutput("mthi_stall", {31'd0, stall}, 32'd1);
        step();
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 32'hA5A5, 32'h1234, 32'h5678);
        checkOutput("mtlo_commit_stall", {31'd0, stall}, 32'd0);
        checkOutput("mf_no_mt_bypass",   mf_data, 32'h5678);
        checkOutput("mthi_not_landed",   hi_in, 32'h1);
        step();
        idleInputs();
        checkOutput("mtlo_hi", hi_in, 32'h1234);
        checkOutput("mtlo_lo", lo_in, 32'hA5A5);

        // Back-to-back: second op starts in the commit cycle of the first
        applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, 32'hAA, 32'hBB);
        checkOutput("b2b_nostall", {31'd0, stall}, 32'd0);
        step();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, '0, 32'hBAD, 32'hBAD);
        checkOutput("b2b_busy",  {31'd0, busy}, 32'd1);
        checkOutput("b2b_hi_in", hi_in, 32'hAA);
        checkOutput("b2b_lo_in", lo_in, 32'hBB);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, '0, 32'hCC, 32'hDD);
        step();
        idleInputs();
        checkOutput("b2b2_hi",   hi_in, 32'hCC);
        checkOutput("b2b2_lo",   lo_in, 32'hDD);
        checkOutput("b2b2_busy", {31'd0, busy}, 32'd0);

        // Reset asserted mid-BUSY
        applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        step();
        applyStimulus(0, 1, 0, 1, 1, 0, 0, '0, 32'h99, 32'h99);
        checkOutput("mid_stall_pre", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_hi",    hi_in, 32'd0);
        checkOutput("mid_rst_lo",    lo_in, 32'd0);
        checkOutput("mid_rst_busy",  {31'd0, busy},     32'd0);
        checkOutput("mid_rst_stall", {31'd0, stall},    32'd0);
        checkOutput("mid_rst_clear", {31'd0, md_clear}, 32'd1);
        step();
        reset = 1'b1;
        idleInputs();
        step();
        checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_rst_hi",   hi_in, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
